fifo: RTL and testbench
=======================

# fifo

Single-clock synchronous FIFO with an integrated safety monitor. It buffers DATA_WIDTH-bit words between a producer and a consumer in the same clock domain, and provides active-low Empty, HalfFull and Full status. A built-in checker raises a sticky Error output when it detects protocol misuse or an internal inconsistency. It sits between datapath stages as a rate-decoupling buffer; Error feeds the system fault aggregator.

## Interface
- FIFO_DEPTH, default 16: number of entries; a power of two, at least 4.
- DATA_WIDTH, default 32: word width in bits.
- Clock  in  1  rising-edge clock for all logic.
- Reset_  in  1  asynchronous, active-low reset.
- WriteEn  in  1  write request; DataIn is captured on the same edge.
- DataIn  in  DATA_WIDTH  write data.
- ReadEn  in  1  read request.
- DataOut  out  DATA_WIDTH  registered read data.
- Empty_  out  1  low when occupancy is 0.
- HalfFull_  out  1  low when occupancy is at least FIFO_DEPTH/2.
- Full_  out  1  low when occupancy equals FIFO_DEPTH.
- Error  out  1  sticky fault flag from the monitor; high means a fault was detected.

## Operation
- Storage is a simple dual-port array named mem_array, FIFO_DEPTH x DATA_WIDTH.
  - It has one write port and one read port.
  - Reset does not clear it.
- Write pointer and read pointer are each log2(FIFO_DEPTH) bits and wrap naturally from FIFO_DEPTH-1 to 0.
- The occupancy counter is log2(FIFO_DEPTH)+1 bits wide, range 0..FIFO_DEPTH.
- An accepted write stores DataIn at the write pointer, then increments the write pointer.
  - A write is accepted when WriteEn=1 and (not full, or an accepted read occurs in the same cycle).
- An accepted read loads DataOut from the read pointer, then increments the read pointer.
  - A read is accepted when ReadEn=1 and not empty.
- Simultaneous read and write:
  - When the FIFO is empty, only the write is accepted. The read is dropped and DataOut holds.
  - When the FIFO is full, both are accepted and occupancy is unchanged.
  - Otherwise both are accepted and occupancy is unchanged.
- Rejected requests leave all pointers and data unchanged.
- DataOut holds its value between reads.
- Flags are decoded combinationally from the registered occupancy counter, so they are glitch-free and reflect the post-edge count.
- Monitor (present when enabled, see Configuration). Error is set on any of:
  - WriteEn=1 while full with no accepted read in the same cycle (overflow attempt).
  - ReadEn=1 while empty (underflow attempt).
  - Occupancy not equal to (write pointer - read pointer) mod FIFO_DEPTH, except at occupancy FIFO_DEPTH, where the pointers must be equal.
  - Empty_ and Full_ both low.
- Error stays high until Reset_ is asserted.

## Timing
- Reset values while Reset_=0:
  - DataOut = 0, Empty_ = 0, HalfFull_ = 1, Full_ = 1, Error = 0.
  - Pointers and count are 0.
- Reset deasserts synchronously to Clock; it is a two-flop synchronized release.
- Reset asserted mid-operation discards all contents immediately.
- Write-to-flag latency: the flags update one edge after the accepted write.
- Read latency: DataOut is valid one cycle after the edge where ReadEn is sampled with the FIFO not empty.
- Write-to-read-visible: a word written at edge N can be read at edge N+1, so it appears on DataOut after edge N+1.
- Error asserts on the edge following the offending sampled condition.

## Configuration
- FIFO_SM_EN defined: the monitor is compiled in and Error behaves as above.
- FIFO_SM_EN undefined: the monitor logic is omitted and Error is tied to 0.
  - FIFO data path and flags are identical in both builds.

## Test plan
- Reset then idle:
  - Stimulus: hold Reset_=0 for 3 cycles, release.
  - Required: Empty_=0, HalfFull_=1, Full_=1, DataOut=0, Error=0.
- Fill and drain:
  - Stimulus: write 0x00000001..0x00000010 (16 words), then read 16 times.
  - Required: HalfFull_ goes low after the 8th write; Full_ goes low after the 16th write.
  - Required: DataOut returns 1..16 in order; Empty_ goes low after the last read.
  - Required: Error=0 throughout.
- Overflow:
  - Stimulus: fill with 16 words, then one more write of 0xDEADBEEF with ReadEn=0.
  - Required: the write is ignored; draining returns the original 16 words.
  - Required: Error=1 (with FIFO_SM_EN); Error=0 (without).
- Underflow:
  - Stimulus: from empty, ReadEn=1 for 1 cycle.
  - Required: DataOut unchanged and Empty_=0.
  - Required: Error=1 (with FIFO_SM_EN).
- Simultaneous read and write at full:
  - Stimulus: fill with A0..A15, then one cycle with WriteEn=1, ReadEn=1, DataIn=0xCAFE0000.
  - Required: DataOut=A0 and Full_ stays low.
  - Required: a further 16 reads return A1..A15, then 0xCAFE0000.
- Wrap-around and reset mid-run:
  - Stimulus: run 40 interleaved writes and reads keeping occupancy at 3..5; then assert Reset_ while occupancy is 4.
  - Required: data order is preserved across pointer wrap.
  - Required: after reset, Empty_=0 and a subsequent read is rejected.

Source files
------------

// File: rtl/fifo_if.sv
// fifo_if: producer/consumer bundle for the synchronous FIFO.
// Ports: WriteEn/DataIn/ReadEn from producer/consumer; DataOut, active-low
//   Empty_/HalfFull_/Full_ flags and sticky Error back from the FIFO.
// master = the side driving requests, slave = the FIFO itself.
interface fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  WriteEn;
  logic [DATA_WIDTH-1:0] DataIn;
  logic                  ReadEn;
  logic [DATA_WIDTH-1:0] DataOut;
  logic                  Empty_;
  logic                  HalfFull_;
  logic                  Full_;
  logic                  Error;

  modport master (
    output WriteEn, DataIn, ReadEn,
    input  DataOut, Empty_, HalfFull_, Full_, Error
  );

  modport slave (
    input  WriteEn, DataIn, ReadEn,
    output DataOut, Empty_, HalfFull_, Full_, Error
  );
endinterface

// File: rtl/fifo.sv
// fifo: single-clock FIFO with an integrated safety monitor (sticky Error).
// Latency: write visible to a read on the next edge; DataOut registered, valid
//   one cycle after an accepted read; flags follow the registered occupancy.
// Backpressure: writes to a full FIFO are dropped unless a read is accepted in
//   the same cycle; reads from an empty FIFO are dropped.
// Ports:
//   Clock   - rising-edge clock for all logic
//   Reset_  - asynchronous active-low reset, release synchronized by two flops
//   bus     - fifo_if.slave: WriteEn, DataIn, ReadEn in; DataOut, Empty_,
//             HalfFull_, Full_, Error out
// Build option: define FIFO_SM_EN to compile in the safety monitor; without it
//   Error is tied low and the data path/flags are unchanged.
module fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic   Clock,
  input  logic   Reset_,
  fifo_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_HALF = (AW+1)'(FIFO_DEPTH / 2);

  // ------------------------------------------------------------------------
  // Reset synchronizer: assertion takes effect immediately (async clear of
  // both flops), release reaches the logic only after two rising edges so
  // that every flop leaves reset on the same clean edge.
  // ------------------------------------------------------------------------
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge Clock or negedge Reset_) begin
    if (!Reset_) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  // ------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_array [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic [DATA_WIDTH-1:0] data_out;

  logic empty;
  logic full;
  logic rd_accept;
  logic wr_accept;

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  // A read needs data. A write needs a free slot, but at full the slot being
  // freed by a same-cycle read can be reused, so the write still goes in.
  assign rd_accept = bus.ReadEn && !empty;
  assign wr_accept = bus.WriteEn && (!full || rd_accept);

  // Storage has no reset: contents are meaningless once count says so.
  always_ff @(posedge Clock) begin
    if (wr_accept) begin
      mem_array[wr_ptr] <= bus.DataIn;
    end
  end

  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (wr_accept) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // The read port samples the old array contents, so a same-cycle write to
  // the slot being read (only possible at full) cannot disturb DataOut.
  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      data_out <= '0;
    end else if (rd_accept) begin
      rd_ptr   <= rd_ptr + PTR_ONE;
      data_out <= mem_array[rd_ptr];
    end
  end

  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Outputs: flags decode straight from the registered count, no extra state.
  // ------------------------------------------------------------------------
  assign bus.DataOut   = data_out;
  assign bus.Empty_    = ~empty;
  assign bus.HalfFull_ = ~(count >= CNT_HALF);
  assign bus.Full_     = ~full;

`ifdef FIFO_SM_EN
  // ------------------------------------------------------------------------
  // Safety monitor. Every term is evaluated on the pre-edge state and inputs;
  // a hit sets Error on that same edge and it stays set until reset.
  // ------------------------------------------------------------------------
  logic [AW-1:0] ptr_diff;
  logic          overflow_try;
  logic          underflow_try;
  logic          ptr_mismatch;
  logic          flag_conflict;
  logic          fault;
  logic          error_q;

  assign ptr_diff = wr_ptr - rd_ptr;

  assign overflow_try  = bus.WriteEn && full && !rd_accept;
  assign underflow_try = bus.ReadEn && empty;

  // At full the modular pointer difference wraps to 0, so the only
  // consistent picture there is equal pointers.
  always_comb begin
    ptr_mismatch = 1'b0;
    if (count > CNT_FULL) begin
      ptr_mismatch = 1'b1;
    end else if (full) begin
      ptr_mismatch = (wr_ptr != rd_ptr);
    end else begin
      ptr_mismatch = (count != {1'b0, ptr_diff});
    end
  end

  // Checked on the driven flag values so a decode fault is caught as well.
  assign flag_conflict = !bus.Empty_ && !bus.Full_;

  assign fault = overflow_try || underflow_try || ptr_mismatch || flag_conflict;

  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else if (fault) begin
      error_q <= 1'b1;
    end
  end

  assign bus.Error = error_q;
`else
  assign bus.Error = 1'b0;
`endif

  // ------------------------------------------------------------------------
  // Structural invariants of the counter/pointer pair.
  // ------------------------------------------------------------------------
  count_in_range: assert property (
    @(posedge Clock) disable iff (!rst_n) count <= CNT_FULL
  );

  ptrs_track_count: assert property (
    @(posedge Clock) disable iff (!rst_n)
      count[AW-1:0] == AW'(wr_ptr - rd_ptr)
  );

endmodule

// File: tb/tb_fifo.sv
// tb_fifo: randomized + directed stimulus against a queue-based reference
// model; expected post-edge outputs go into a scoreboard queue and a separate
// monitor compares them one cycle at a time.
module tb_fifo;

  localparam int DEPTH = 16;
  localparam int DW    = 32;

`ifdef FIFO_SM_EN
  localparam bit SM_EN = 1'b1;
`else
  localparam bit SM_EN = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] dout;
    logic          empty_n;
    logic          half_n;
    logic          full_n;
    logic          err;
    string         tag;
  } exp_t;

  logic clk;
  logic rst_n;

  fifo_if #(.DATA_WIDTH(DW)) bus ();

  fifo #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .Clock  (clk),
    .Reset_ (rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  exp_t          exp_q[$];
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] m_dout;
  logic          m_err;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue; acceptance rules come straight
  // from occupancy, the monitor from overflow/underflow attempts.
  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
    exp_t e;
    bit   is_empty;
    bit   is_full;
    bit   rd_ok;
    bit   wr_ok;
    @(negedge clk);
    bus.WriteEn = w;
    bus.ReadEn  = r;
    bus.DataIn  = d;
    is_empty = (model_q.size() == 0);
    is_full  = (model_q.size() == DEPTH);
    rd_ok    = r && !is_empty;
    wr_ok    = w && (!is_full || rd_ok);
    if (SM_EN && ((w && is_full && !rd_ok) || (r && is_empty))) m_err = 1'b1;
    if (rd_ok) m_dout = model_q.pop_front();
    if (wr_ok) model_q.push_back(d);
    e.dout    = m_dout;
    e.empty_n = (model_q.size() != 0);
    e.half_n  = !(model_q.size() >= DEPTH / 2);
    e.full_n  = (model_q.size() != DEPTH);
    e.err     = m_err;
    e.tag     = tag;
    exp_q.push_back(e);
  endtask

  task automatic check_idle_reset_vals(input string tag);
    chk({tag, ".DataOut"},   bus.DataOut,   '0);
    chk({tag, ".Empty_"},    {31'd0, bus.Empty_},    32'd0);
    chk({tag, ".HalfFull_"}, {31'd0, bus.HalfFull_}, 32'd1);
    chk({tag, ".Full_"},     {31'd0, bus.Full_},     32'd1);
    chk({tag, ".Error"},     {31'd0, bus.Error},     32'd0);
  endtask

  // Reset takes effect at once; release needs two edges to pass the synchronizer.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n       = 1'b0;
    bus.WriteEn = 1'b0;
    bus.ReadEn  = 1'b0;
    bus.DataIn  = '0;
    model_q.delete();
    m_dout = '0;
    m_err  = 1'b0;
    #1;
    check_idle_reset_vals({tag, ".in_reset"});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_reset_vals({tag, ".released"});
  endtask

  task automatic idle();
    @(negedge clk);
    bus.WriteEn = 1'b0;
    bus.ReadEn  = 1'b0;
  endtask

  // Monitor: one expected entry per stimulus cycle, compared after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, ".DataOut"},   bus.DataOut, e.dout);
        chk({e.tag, ".Empty_"},    {31'd0, bus.Empty_},    {31'd0, e.empty_n});
        chk({e.tag, ".HalfFull_"}, {31'd0, bus.HalfFull_}, {31'd0, e.half_n});
        chk({e.tag, ".Full_"},     {31'd0, bus.Full_},     {31'd0, e.full_n});
        chk({e.tag, ".Error"},     {31'd0, bus.Error},     {31'd0, e.err});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int occ;
    rst_n       = 1'b0;
    bus.WriteEn = 1'b0;
    bus.ReadEn  = 1'b0;
    bus.DataIn  = '0;
    m_dout      = '0;
    m_err       = 1'b0;

    do_reset("reset_idle");

    // Fill and drain
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, DW'(i), "fill");
    for (int i = 0; i < DEPTH; i++)  cycle(1'b0, 1'b1, '0, "drain");
    idle();

    // Overflow
    do_reset("pre_overflow");
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, $urandom, "ovf_fill");
    cycle(1'b1, 1'b0, 32'hDEADBEEF, "ovf_write");
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, '0, "ovf_drain");
    idle();

    // Underflow
    do_reset("pre_underflow");
    cycle(1'b0, 1'b1, '0, "underflow");
    idle();

    // Simultaneous read and write at full
    do_reset("pre_rw_full");
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 32'hA000_0000 + DW'(i), "rwf_fill");
    cycle(1'b1, 1'b1, 32'hCAFE_0000, "rwf_both");
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, '0, "rwf_drain");
    idle();

    // Wrap-around with occupancy held at 3..5
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, $urandom, "wrap_prime");
    for (int i = 0; i < 40; i++) begin
      occ = model_q.size();
      if (occ <= 3)      cycle(1'b1, 1'($urandom_range(0, 1)), $urandom, "wrap");
      else if (occ >= 5) cycle(1'($urandom_range(0, 1)), 1'b1, $urandom, "wrap");
      else begin
        case ($urandom_range(0, 2))
          0:       cycle(1'b1, 1'b0, $urandom, "wrap");
          1:       cycle(1'b0, 1'b1, $urandom, "wrap");
          default: cycle(1'b1, 1'b1, $urandom, "wrap");
        endcase
      end
    end
    while (model_q.size() < 4) cycle(1'b1, 1'b0, $urandom, "wrap_to4");
    while (model_q.size() > 4) cycle(1'b0, 1'b1, '0, "wrap_to4");

    // Reset mid-run with occupancy 4, then a read that must be rejected
    do_reset("mid_reset");
    cycle(1'b0, 1'b1, '0, "post_reset_read");
    idle();

    // Random traffic, including overflow/underflow attempts
    do_reset("pre_random");
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), $urandom, "random");
    end
    while (model_q.size() > 0) cycle(1'b0, 1'b1, '0, "random_drain");
    idle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
